alu_branch_unit: RTL and testbench

Execute-stage arithmetic and control-flow block of the single-cycle RV32I core. It combines three functions: ALU operation decode (from ALUOp/funct3/funct7), the 32-bit ALU, and branch/jump resolution. It produces the ALU result, which serves as the data-memory address, writeback value or JALR target. It also produces the 2-bit next-PC select consumed by the PC mux: bit1 selects the JALR target, bit0 selects PC+(imm<<1), and 00 selects PC+4.

---
 rtl/core_pkg.sv | 44 ++++
 rtl/alu_branch_unit_if.sv | 25 ++
 rtl/alu_branch_unit_datapath.sv | 36 +++
 rtl/alu_branch_unit.sv | 81 ++++++++
 tb/tb_alu_branch_unit.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, ALU class/operation codes, jump control and next-PC select codes.
package core_pkg;

    localparam int unsigned WORD_SIZE = 32;
    localparam int unsigned SHAMT_W   = 5;

    typedef logic [WORD_SIZE-1:0] data_t;

    typedef enum logic [2:0] {
        ALUOP_ADD    = 3'b000,
        ALUOP_BRANCH = 3'b001,
        ALUOP_RTYPE  = 3'b010,
        ALUOP_ITYPE  = 3'b011,
        ALUOP_LUI    = 3'b100
    } alu_op_e;

    typedef enum logic [3:0] {
        OP_AND    = 4'b0000,
        OP_OR     = 4'b0001,
        OP_ADD    = 4'b0010,
        OP_XOR    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRL    = 4'b0101,
        OP_SUB    = 4'b0110,
        OP_SRA    = 4'b0111,
        OP_SLT    = 4'b1000,
        OP_SLTU   = 4'b1001,
        OP_PASS_B = 4'b1010
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        CJ_NONE   = 2'b00,
        CJ_BRANCH = 2'b01,
        CJ_JAL    = 2'b10,
        CJ_JALR   = 2'b11
    } ctrl_jump_e;

    typedef enum logic [1:0] {
        BJ_PC4    = 2'b00,
        BJ_TARGET = 2'b01,
        BJ_JALR   = 2'b10
    } bj_result_e;

endpackage

// File: rtl/alu_branch_unit_if.sv
// Execute-stage bus: decode inputs and operands in, ALU result and next-PC select out.
interface alu_branch_unit_if;

    logic [2:0]          i_ALUOp;
    logic [2:0]          i_Funct3;
    logic [6:0]          i_Funct7;
    logic [1:0]          i_Ctrl_Jump;
    core_pkg::data_t     i_Op1;
    core_pkg::data_t     i_Op2;
    core_pkg::data_t     o_Result;
    logic                o_Zero;
    logic [3:0]          o_Operation;
    logic [1:0]          o_B_J_result;

    modport master (
        output i_ALUOp, i_Funct3, i_Funct7, i_Ctrl_Jump, i_Op1, i_Op2,
        input  o_Result, o_Zero, o_Operation, o_B_J_result
    );

    modport slave (
        input  i_ALUOp, i_Funct3, i_Funct7, i_Ctrl_Jump, i_Op1, i_Op2,
        output o_Result, o_Zero, o_Operation, o_B_J_result
    );

endinterface

// File: rtl/alu_branch_unit_datapath.sv
// 32-bit ALU: applies the decoded operation to both operands; zero flag comes from the result.
module alu_datapath
    import core_pkg::*;
(
    input  alu_ctrl_e op_i,
    input  data_t     op1_i,
    input  data_t     op2_i,
    output data_t     result_o,
    output logic      zero_o
);

    logic [SHAMT_W-1:0] shamt;

    assign shamt = op2_i[SHAMT_W-1:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_AND:    result_o = op1_i & op2_i;
            OP_OR:     result_o = op1_i | op2_i;
            OP_ADD:    result_o = op1_i + op2_i;
            OP_XOR:    result_o = op1_i ^ op2_i;
            OP_SLL:    result_o = op1_i << shamt;
            OP_SRL:    result_o = op1_i >> shamt;
            OP_SUB:    result_o = op1_i - op2_i;
            OP_SRA:    result_o = data_t'($signed(op1_i) >>> shamt);
            OP_SLT:    result_o = data_t'($signed(op1_i) < $signed(op2_i));
            OP_SLTU:   result_o = data_t'(op1_i < op2_i);
            OP_PASS_B: result_o = op2_i;
            default:   result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_branch_unit.sv
// Execute stage of the single-cycle core: ALU control decode, ALU, and branch/jump next-PC select.
module alu_branch_unit
    import core_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rstn,
    alu_branch_unit_if.slave   bus
);

    alu_ctrl_e  operation;
    bj_result_e bj_sel;
    data_t      result;
    logic       zero;
    logic       f7_alt;

    // Clock and reset are reserved for a future pipelined version.
    logic unused_ok;
    assign unused_ok = &{1'b0, i_clk, i_rstn, bus.i_Funct7[6], bus.i_Funct7[4:0]};

    assign f7_alt = bus.i_Funct7[5];

    // ALU control decode from instruction class and function fields.
    always_comb begin
        operation = OP_ADD;
        case (bus.i_ALUOp)
            ALUOP_ADD: operation = OP_ADD;
            ALUOP_LUI: operation = OP_PASS_B;
            ALUOP_BRANCH: begin
                case (bus.i_Funct3)
                    3'b100, 3'b101: operation = OP_SLT;
                    3'b110, 3'b111: operation = OP_SLTU;
                    default:        operation = OP_SUB;
                endcase
            end
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (bus.i_Funct3)
                    3'b000: operation = (bus.i_ALUOp == ALUOP_RTYPE && f7_alt) ? OP_SUB : OP_ADD;
                    3'b001: operation = OP_SLL;
                    3'b010: operation = OP_SLT;
                    3'b011: operation = OP_SLTU;
                    3'b100: operation = OP_XOR;
                    3'b101: operation = f7_alt ? OP_SRA : OP_SRL;
                    3'b110: operation = OP_OR;
                    default: operation = OP_AND;
                endcase
            end
            default: operation = OP_ADD;
        endcase
    end

    alu_datapath u_alu_datapath (
        .op_i     (operation),
        .op1_i    (bus.i_Op1),
        .op2_i    (bus.i_Op2),
        .result_o (result),
        .zero_o   (zero)
    );

    // Branch resolution: SLT/SLTU results are 1 when "less than", so Zero inverts the sense.
    always_comb begin
        bj_sel = BJ_PC4;
        case (bus.i_Ctrl_Jump)
            CJ_JAL:  bj_sel = BJ_TARGET;
            CJ_JALR: bj_sel = BJ_JALR;
            CJ_BRANCH: begin
                case (bus.i_Funct3)
                    3'b000, 3'b101, 3'b111: bj_sel = zero ? BJ_TARGET : BJ_PC4;
                    3'b001, 3'b100, 3'b110: bj_sel = zero ? BJ_PC4 : BJ_TARGET;
                    default:                bj_sel = BJ_PC4;
                endcase
            end
            default: bj_sel = BJ_PC4;
        endcase
    end

    assign bus.o_Result     = result;
    assign bus.o_Zero       = zero;
    assign bus.o_Operation  = operation;
    assign bus.o_B_J_result = bj_sel;

endmodule

// File: tb/tb_alu_branch_unit.sv
// Self-checking bench for alu_branch_unit: directed cases plus randomized vectors against a behavioural model.
module tb_alu_branch_unit;

    logic clk;
    logic rstn;
    int   n_total;
    int   n_bad;

    alu_branch_unit_if bus ();

    alu_branch_unit u_dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [1:0] cj, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.i_ALUOp     = aop;
        bus.i_Funct3    = f3;
        bus.i_Funct7    = f7;
        bus.i_Ctrl_Jump = cj;
        bus.i_Op1       = a;
        bus.i_Op2       = b;
        #1;
    endtask

    // Behavioural reference: instruction semantics computed directly from the rules.
    function automatic void model(input logic [2:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [1:0] cj, input logic [31:0] a, input logic [31:0] b,
                                  output logic [3:0] op, output logic [31:0] r, output logic [1:0] bj);
        logic [4:0] sh;
        logic       z;
        sh = b[4:0];
        if (aop == 3'd4)
            op = 4'b1010;
        else if (aop == 3'd1)
            op = (f3[2] == 1'b0) ? 4'b0110 : (f3[1] ? 4'b1001 : 4'b1000);
        else if (aop == 3'd2 || aop == 3'd3) begin
            case (f3)
                3'd0: op = (aop == 3'd2 && f7[5]) ? 4'b0110 : 4'b0010;
                3'd1: op = 4'b0100;
                3'd2: op = 4'b1000;
                3'd3: op = 4'b1001;
                3'd4: op = 4'b0011;
                3'd5: op = f7[5] ? 4'b0111 : 4'b0101;
                3'd6: op = 4'b0001;
                default: op = 4'b0000;
            endcase
        end else
            op = 4'b0010;

        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = 32'(64'(a) + 64'(b));
            4'b0011: r = a ^ b;
            4'b0100: r = 32'(64'(a) * (64'd1 << sh));
            4'b0101: r = a >> sh;
            4'b0110: r = a + ~b + 32'd1;
            4'b0111: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'b1000: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'b1001: r = (a < b) ? 32'd1 : 32'd0;
            default: r = b;
        endcase

        z = (r == 32'd0);
        case (cj)
            2'd0: bj = 2'b00;
            2'd2: bj = 2'b01;
            2'd3: bj = 2'b10;
            default: begin
                if (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7)      bj = z ? 2'b01 : 2'b00;
                else if (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6) bj = z ? 2'b00 : 2'b01;
                else                                              bj = 2'b00;
            end
        endcase
    endfunction

    task automatic check_all(input string tag, input logic [31:0] er, input logic ez,
                             input logic [3:0] eop, input logic [1:0] ebj);
        check_val({tag, ".result"}, bus.o_Result, er);
        check_val({tag, ".zero"},   32'(bus.o_Zero), 32'(ez));
        check_val({tag, ".op"},     32'(bus.o_Operation), 32'(eop));
        check_val({tag, ".bj"},     32'(bus.o_B_J_result), 32'(ebj));
    endtask

    initial begin
        logic [2:0]  aop, f3;
        logic [6:0]  f7;
        logic [1:0]  cj, ebj;
        logic [31:0] a, b, er;
        logic [3:0]  eop;

        clk     = 1'b0;
        rstn    = 1'b0;
        n_total = 0;
        n_bad   = 0;
        bus.i_ALUOp = '0; bus.i_Funct3 = '0; bus.i_Funct7 = '0;
        bus.i_Ctrl_Jump = '0; bus.i_Op1 = '0; bus.i_Op2 = '0;

        // Outputs follow inputs while reset is asserted.
        drive(3'd0, 3'd0, 7'h00, 2'd0, 32'd3, 32'd4);
        check_all("rst_add", 32'd7, 1'b0, 4'b0010, 2'b00);
        rstn = 1'b1;

        drive(3'd2, 3'd0, 7'h20, 2'd0, 32'd5, 32'd7);
        check_all("r_sub", 32'hFFFF_FFFE, 1'b0, 4'b0110, 2'b00);
        drive(3'd3, 3'd0, 7'h20, 2'd0, 32'd5, 32'd7);
        check_all("i_add_f7", 32'd12, 1'b0, 4'b0010, 2'b00);
        drive(3'd3, 3'd5, 7'h20, 2'd0, 32'h8000_0000, 32'd4);
        check_all("i_sra", 32'hF800_0000, 1'b0, 4'b0111, 2'b00);
        drive(3'd3, 3'd5, 7'h00, 2'd0, 32'h8000_0000, 32'd4);
        check_all("i_srl", 32'h0800_0000, 1'b0, 4'b0101, 2'b00);
        drive(3'd2, 3'd2, 7'h00, 2'd0, 32'hFFFF_FFFF, 32'd1);
        check_all("slt", 32'd1, 1'b0, 4'b1000, 2'b00);
        drive(3'd2, 3'd3, 7'h00, 2'd0, 32'hFFFF_FFFF, 32'd1);
        check_all("sltu", 32'd0, 1'b1, 4'b1001, 2'b00);
        drive(3'd1, 3'd0, 7'h00, 2'd1, 32'd9, 32'd9);
        check_all("beq", 32'd0, 1'b1, 4'b0110, 2'b01);
        drive(3'd1, 3'd1, 7'h00, 2'd1, 32'd9, 32'd9);
        check_all("bne", 32'd0, 1'b1, 4'b0110, 2'b00);
        drive(3'd1, 3'd5, 7'h00, 2'd1, 32'hFFFF_FFFD, 32'd2);
        check_all("bge", 32'd1, 1'b0, 4'b1000, 2'b00);
        drive(3'd1, 3'd4, 7'h00, 2'd1, 32'hFFFF_FFFD, 32'd2);
        check_all("blt", 32'd1, 1'b0, 4'b1000, 2'b01);
        drive(3'd1, 3'd2, 7'h00, 2'd1, 32'd9, 32'd9);
        check_all("b010", 32'd0, 1'b1, 4'b0110, 2'b00);
        for (int i = 0; i < 4; i++) begin
            drive(3'd0, 3'($urandom_range(0, 7)), 7'h00, 2'd2, $urandom(), $urandom());
            check_val("jal.bj", 32'(bus.o_B_J_result), 32'd1);
        end
        drive(3'd0, 3'd0, 7'h00, 2'd3, 32'h100, 32'h7);
        check_all("jalr", 32'h107, 1'b0, 4'b0010, 2'b10);
        drive(3'd6, 3'd7, 7'h20, 2'd0, 32'd1, 32'd2);
        check_all("aluop6", 32'd3, 1'b0, 4'b0010, 2'b00);

        drive(3'd4, 3'd0, 7'h00, 2'd0, 32'hDEAD_0000, 32'h1234_5000);
        check_all("lui", 32'h1234_5000, 1'b0, 4'b1010, 2'b00);
        rstn = 1'b0;
        #3;
        check_all("lui_rst", 32'h1234_5000, 1'b0, 4'b1010, 2'b00);
        @(posedge clk);
        rstn = 1'b1;
        #3;
        check_all("lui_rel", 32'h1234_5000, 1'b0, 4'b1010, 2'b00);

        for (int i = 0; i < 400; i++) begin
            aop = 3'($urandom_range(0, 7));
            f3  = 3'($urandom_range(0, 7));
            f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom());
            cj  = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom();
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = 32'($urandom_range(0, 40));
                default: b = $urandom();
            endcase
            drive(aop, f3, f7, cj, a, b);
            model(aop, f3, f7, cj, a, b, eop, er, ebj);
            check_all($sformatf("rnd%0d", i), er, (er == 32'd0), eop, ebj);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
